// File: rtl/nrda_div_seq_if.sv
// Start/done handshake bundle for the sequential divider.
// The master issues start/x/y, and the divider answers on busy/done/q/r.
interface nrda_div_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;

   modport master (
      output start, x, y,
      input  busy, done, q, r
   );

   modport slave (
      input  start, x, y,
      output busy, done, q, r
   );
endinterface

// File: rtl/nrda_div_seq.sv
// Unsigned divider using non-restoring division, one quotient bit per clock.
// Latency from accepted start to done is WIDTH+1 edges, independent of the operands.
module nrda_div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   nrda_div_seq_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

   state_e                  state_q, state_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic [WIDTH-1:0]        d_q, d_d;
   logic [WIDTH-1:0]        quo_q, quo_d;
   logic [WIDTH-1:0]        q_q, q_d;
   logic [WIDTH-1:0]        r_q, r_d;
   logic signed [WIDTH+1:0] p_q, p_d;
   logic signed [WIDTH+1:0] p_shift, d_ext;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         q_q     <= q_d;
         r_q     <= r_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      quo_d   = quo_q;
      q_d     = q_q;
      r_d     = r_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      d_ext   = signed'({2'b00, d_q});
      p_shift = signed'({p_q[WIDTH:0], a_q[WIDTH-1]});

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.x;
               d_d     = bus.y;
               p_d     = '0;
               quo_d   = '0;
               cnt_d   = '0;
               state_d = StIter;
            end
         end
         StIter: begin
            // Sign of P picks subtract or add back; the new sign gives the quotient bit.
            p_d   = p_q[WIDTH+1] ? (p_shift + d_ext) : (p_shift - d_ext);
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            quo_d = {quo_q[WIDTH-2:0], ~p_d[WIDTH+1]};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            // With D=0 P never goes negative, so q ends all ones and r ends equal to x.
            p_d     = p_q[WIDTH+1] ? (p_q + d_ext) : p_q;
            q_d     = quo_q;
            r_d     = p_d[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;
   assign bus.q    = q_q;
   assign bus.r    = r_q;
endmodule

// File: tb/tb_nrda_div_seq.sv
// Randomized and directed checks of nrda_div_seq against a cycle-count reference model.
module tb_nrda_div_seq;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nrda_div_seq_if #(.WIDTH(W)) bus ();

   nrda_div_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Reference model: a countdown of remaining edges plus the arithmetic result.
   int           m_cnt;
   logic         m_done;
   logic [W-1:0] m_q, m_r, m_pq, m_pr;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
      end else begin
         m_done <= (m_cnt == 1);
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_q <= m_pq;
               m_r <= m_pr;
            end
         end else if (bus.start) begin
            m_cnt <= W + 1;
            m_pq  <= (bus.y == 0) ? '1 : bus.x / bus.y;
            m_pr  <= (bus.y == 0) ? bus.x : bus.x % bus.y;
         end
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", W'(bus.busy), W'(m_cnt != 0));
         chk("done", W'(bus.done), W'(m_done));
         chk("q", bus.q, m_q);
         chk("r", bus.r, m_r);
      end
   end

   // Issue a one-cycle start; returns at the negedge after the accepting edge.
   task automatic go(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit now);
      if (!now) @(negedge clk);
      bus.start = 1'b1;
      bus.x     = xv;
      bus.y     = yv;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Wait for done; optionally pulse a junk start at cycle junk_at (0 = none).
   task automatic wait_done(output int n, input int junk_at);
      n = 0;
      while (!bus.done && n < 100) begin
         if (junk_at != 0 && n == junk_at) begin
            bus.start = 1'b1;
            bus.x     = $urandom;
            bus.y     = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      chk("done_seen", W'(bus.done), W'(1));
   endtask

   logic [W-1:0] dx[8] = '{32'd1436, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'd5, 32'd0, 32'd1234, 32'd100};
   logic [W-1:0] dy[8] = '{32'd135, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                           32'd7, 32'd9, 32'd0, 32'd7};
   logic [W-1:0] dq[8] = '{32'd10, 32'hFFFFFFFF, 32'd1, 32'd1,
                           32'd0, 32'd0, 32'hFFFFFFFF, 32'd14};
   logic [W-1:0] dr[8] = '{32'd86, 32'd0, 32'd0, 32'h7FFFFFFF,
                           32'd5, 32'd0, 32'd1234, 32'd2};

   initial begin
      int n;
      int dones;
      logic [W-1:0] rx, ry;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", W'(bus.busy), W'(0));
      chk("rst_done", W'(bus.done), W'(0));
      chk("rst_q", bus.q, '0);
      chk("rst_r", bus.r, '0);
      rst = 1'b0;

      // Directed vectors with hand-computed results and fixed latency.
      for (int i = 0; i < 8; i++) begin
         go(dx[i], dy[i], 1'b0);
         wait_done(n, 0);
         chk("latency", W'(n), W'(W + 1));
         chk("dir_q", bus.q, dq[i]);
         chk("dir_r", bus.r, dr[i]);
      end

      // Start mid-operation is ignored.
      go(32'd1000, 32'd3, 1'b0);
      wait_done(n, 5);
      chk("ign_q", bus.q, 32'd333);
      chk("ign_r", bus.r, 32'd1);

      // Back-to-back: start in the done cycle.
      go(32'd1436, 32'd135, 1'b0);
      wait_done(n, 0);
      go(32'd100, 32'd7, 1'b1);
      wait_done(n, 0);
      chk("b2b_lat", W'(n), W'(W + 1));
      chk("b2b_q", bus.q, 32'd14);
      chk("b2b_r", bus.r, 32'd2);

      // Reset during an operation aborts it with no done pulse.
      go(32'd999, 32'd13, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", W'(bus.busy), W'(0));
      chk("abort_q", bus.q, '0);
      chk("abort_r", bus.r, '0);
      rst   = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_nodone", W'(dones), W'(0));
      go(32'd77, 32'd10, 1'b0);
      wait_done(n, 0);
      chk("post_q", bus.q, 32'd7);
      chk("post_r", bus.r, 32'd7);

      // Random operands of varied magnitude, random back-to-back and junk starts.
      for (int i = 0; i < 1000; i++) begin
         rx = $urandom >> ($urandom_range(0, 31));
         ry = $urandom >> ($urandom_range(0, 31));
         if (ry == 0) ry = 1;
         go(rx, ry, ($urandom_range(0, 3) == 0));
         wait_done(n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
         chk("rnd_q", bus.q, rx / ry);
         chk("rnd_r", bus.r, rx % ry);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/nrda_div_seq.md
Name: nrda_div_seq

Overview:
Sequential unsigned integer divider using the non-restoring division algorithm (NRDA), one quotient bit per clock. It takes a WIDTH-bit dividend x and divisor y and produces a WIDTH-bit quotient q and remainder r with x = q*y + r and r < y. It is an arithmetic leaf block in the AddMulDiv unit, driven by a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; x,y sampled on the edge where start=1 and busy=0
x  input  WIDTH  unsigned dividend
y  input  WIDTH  unsigned divisor
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when q/r are updated
q  output  WIDTH  unsigned quotient (registered)
r  output  WIDTH  unsigned remainder (registered)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, q=0, r=0, iteration counter=0. Reset overrides everything, including an operation in progress (aborted; no done pulse).
- States: IDLE, ITER, FIX.
- IDLE: busy=0. On an edge with start=1: latch D=y, dividend shift register A=x, signed partial remainder P=0 (WIDTH+2 bits), count=0 -> ITER.
- ITER (busy=1), one iteration per edge:
  - Shift: P' = (P<<1) | msb(A); A <<= 1.
  - If P>=0: P = P' - D; else P = P' + D.
  - Quotient bit shifted into the LSB of the quotient register = 1 if new P>=0, else 0.
  - After WIDTH iterations -> FIX.
- FIX (busy=1), one edge: if P<0 then P += D (remainder correction). Load q=quotient register, r=P[WIDTH-1:0]; done=1 for exactly this following cycle; -> IDLE.
- Latency: start sampled at edge E0; q/r/done valid after edge E(WIDTH+1) (33 edges for WIDTH=32). Fixed; independent of operand values.
- done is high for one cycle only; q and r hold their values until the next completion or reset.
- busy falls together with done rising; a start in the done cycle is accepted (back-to-back operation).
- start while busy=1 is ignored; x,y changes during operation have no effect.
- Divide by zero (latched D=0): same latency and done pulse; result forced to q = all ones, r = x (the dividend latched at start).
- x<y: q=0, r=x. y=1: q=x, r=0.
- Full-range unsigned: no overflow possible; internal P must be WIDTH+2 bits wide so that 2P+1 +/- D never wraps.

Test Plan:
- Nominal: x=1436, y=135, start pulse -> 33 cycles later done=1, q=10, r=86; busy high for those 33 cycles.
- Extremes: x=32'hFFFFFFFF, y=1 -> q=32'hFFFFFFFF, r=0; x=32'hFFFFFFFF, y=32'hFFFFFFFF -> q=1, r=0; x=32'hFFFFFFFF, y=32'h80000000 -> q=1, r=32'h7FFFFFFF.
- Small dividend: x=5, y=7 -> q=0, r=5; x=0, y=9 -> q=0, r=0.
- Divide by zero: x=1234, y=0 -> after 33 cycles done=1, q=32'hFFFFFFFF, r=1234.
- Handshake: start asserted again mid-operation with different x,y -> ignored, first result unchanged; start in the done cycle with x=100, y=7 -> second done 33 cycles later, q=14, r=2.
- Reset mid-operation: rst=1 at cycle 10 of a division -> busy=0, q=0, r=0, no done pulse; a new start afterwards completes normally.
- Random: 1000 random x,y (y!=0) -> q==x/y, r==x%y for every done pulse.
